// File: rtl/stage_pkg.sv
// Shared opcodes, stage encoding and constants for the stage datapath.
package stage_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    NUM1,
    NUM2,
    OP,
    ANS
  } stage_e;

  // The selector may raise several levels at once; later stages win.
  function automatic stage_e decode_stage(input logic store_num1,
                                          input logic store_num2,
                                          input logic display_16bit_switches,
                                          input logic display_operation,
                                          input logic display_32bit_answer);
    if (display_32bit_answer)                        return ANS;
    else if (display_operation)                      return OP;
    else if (store_num2)                             return NUM2;
    else if (store_num1 && display_16bit_switches)   return NUM1;
    else                                             return IDLE;
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
module seq_muldiv
  import stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(ITER + 1);

  logic            busy_q, busy_d;
  logic            div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   acc_q, acc_d;      // product accumulator, or remainder in the low half
  logic [RW-1:0]   mcand_q, mcand_d;  // shifting multiplicand, or divisor in the low half
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier bits, or dividend/quotient shift
  logic [WIDTH:0]  rem_sh, rem_next;
  logic            q_bit;
  logic            last;

  assign last = (cnt_q == CW'(ITER - 1));

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_d   = busy_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_sh   = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
    rem_next = rem_sh;
    q_bit    = 1'b0;

    if (start) begin
      busy_d   = 1'b1;
      div_d    = (mode == OP_DIV);
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = (mode == OP_DIV) ? RW'(b) : RW'(a);
      mplier_d = (mode == OP_DIV) ? a : b;
    end else if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (div_q) begin
        if (rem_sh >= {1'b0, mcand_q[WIDTH-1:0]}) begin
          rem_next = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
          q_bit    = 1'b1;
        end
        acc_d    = RW'(rem_next[WIDTH-1:0]);
        mplier_d = {mplier_q[WIDTH-2:0], q_bit};
      end else begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
      cnt_d = cnt_q + 1'b1;
      if (last) busy_d = 1'b0;
    end
  end

  // The final iteration's result is presented combinationally so the
  // consumer can register it on the same edge the engine goes idle.
  assign done   = busy_q && last && !abort && !start;
  assign result = div_q ? {acc_d[WIDTH-1:0], mplier_d} : acc_d;
  assign busy   = busy_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  // NOTE: the asynchronous active-low reset clears state without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/stage_datapath.sv
// Operand capture, launch/abort control and display mux driven by the stage selector levels.
module stage_datapath
  import stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   sw,
  input  logic               store_num1,
  input  logic               store_num2,
  input  logic               store_operation,
  input  logic               display_16bit_switches,
  input  logic               display_operation,
  input  logic               display_32bit_answer,
  output logic [2*WIDTH-1:0] display_value,
  output logic               busy,
  output logic               answer_valid,
  output logic               div_zero
);

  localparam int RW = 2 * WIDTH;

  stage_e           stage;
  logic             ans, start;
  logic             eng_start, eng_done, eng_busy;
  logic [RW-1:0]    eng_result;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [RW-1:0]    result_q, result_d;
  logic [RW-1:0]    display_q, display_d;
  logic             valid_q, valid_d;
  logic             dz_q, dz_d;
  logic             prev_ans_q;

  // The operation stage is recognised from display_operation alone.
  logic unused_store_operation;
  assign unused_store_operation = store_operation;

  assign stage = decode_stage(store_num1, store_num2, display_16bit_switches,
                              display_operation, display_32bit_answer);
  assign ans   = (stage == ANS);
  assign start = ans && !prev_ans_q;

  assign eng_start = start && op_q[1] && !((op_q == OP_DIV) && (b_q == '0));

  seq_muldiv #(.WIDTH(WIDTH), .ITER(ITER)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (eng_start),
    .mode   (op_q),
    .a      (a_q),
    .b      (b_q),
    .abort  (!ans),
    .busy   (eng_busy),
    .done   (eng_done),
    .result (eng_result)
  );

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    valid_d   = valid_q;
    dz_d      = dz_q;
    display_d = '0;

    unique case (stage)
      NUM1:    a_d  = sw;
      NUM2:    b_d  = sw;
      OP:      op_d = sw[1:0];
      default: ;
    endcase

    if (!ans) begin
      valid_d = 1'b0;
    end else if (start) begin
      dz_d    = 1'b0;
      valid_d = 1'b0;
      unique case (op_q)
        OP_ADD: begin
          result_d = RW'(a_q) + RW'(b_q);
          valid_d  = 1'b1;
        end
        OP_SUB: begin
          result_d = RW'(a_q) - RW'(b_q);
          valid_d  = 1'b1;
        end
        OP_DIV: begin
          if (b_q == '0) begin
            result_d = RW'(DIV0_RESULT);
            dz_d     = 1'b1;
            valid_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (eng_done) begin
      result_d = eng_result;
      valid_d  = 1'b1;
    end

    // Built from next-state values so a finished answer shows on the same edge it becomes valid.
    unique case (stage)
      NUM1, NUM2: display_d = RW'(sw);
      OP:         display_d = RW'(sw[1:0]);
      ANS:        display_d = valid_d ? result_d : '0;
      default:    display_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      result_q   <= '0;
      display_q  <= '0;
      valid_q    <= 1'b0;
      dz_q       <= 1'b0;
      prev_ans_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      display_q  <= display_d;
      valid_q    <= valid_d;
      dz_q       <= dz_d;
      prev_ans_q <= ans;
    end
  end

  assign display_value = display_q;
  assign busy          = eng_busy;
  assign answer_valid  = valid_q;
  assign div_zero      = dz_q;

endmodule

// File: tb/tb_stage_datapath.sv
// Directed bench for stage_datapath: expected answers are queued at launch and matched when answer_valid rises.
module tb_stage_datapath;

  typedef struct {
    logic [31:0] value;
    logic        dz;
    int          lat;
    int          launch;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = '0;
  logic        store_num1 = 1'b0;
  logic        store_num2 = 1'b0;
  logic        store_operation = 1'b0;
  logic        display_16bit_switches = 1'b0;
  logic        display_operation = 1'b0;
  logic        display_32bit_answer = 1'b0;
  logic [31:0] display_value;
  logic        busy, answer_valid, div_zero;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   busy_total = 0;
  bit   seen_valid = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stage_datapath #(.WIDTH(16), .ITER(16)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .sw                     (sw),
    .store_num1             (store_num1),
    .store_num2             (store_num2),
    .store_operation        (store_operation),
    .display_16bit_switches (display_16bit_switches),
    .display_operation      (display_operation),
    .display_32bit_answer   (display_32bit_answer),
    .display_value          (display_value),
    .busy                   (busy),
    .answer_valid           (answer_valid),
    .div_zero               (div_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard side: runs alongside the stimulus and consumes one expectation per result.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_total++;
      if (answer_valid === 1'b1 && !seen_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got display_value %h, required no result", display_value);
        end else begin
          e = exp_q.pop_front();
          check("result_value", display_value, e.value);
          check("result_div_zero", {31'h0, div_zero}, {31'h0, e.dz});
          check("result_latency", 32'(cyc - e.launch), 32'(e.lat));
        end
      end
      seen_valid = (answer_valid === 1'b1);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    store_num1 = 1'b1; display_16bit_switches = 1'b1; sw = a;
    tick();
    check("num1_display", display_value, {16'h0, a});
    store_num1 = 1'b0; display_16bit_switches = 1'b0; store_num2 = 1'b1; sw = b;
    tick();
    check("num2_display", display_value, {16'h0, b});
    store_num2 = 1'b0; display_operation = 1'b1; sw = {14'h0, op};
    tick();
    check("op_display", display_value, {30'h0, op});
    display_operation = 1'b0; sw = 16'hA5A5;
    tick();
    check("idle_display", display_value, 32'h0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: got no answer_valid within %0d cycles, required one", budget);
      exp_q.delete();
    end
  endtask

  task automatic run(input string tag, input logic [31:0] val, input logic dz,
                     input int lat, input int exp_busy);
    int b0 = busy_total;
    exp_q.push_back('{val, dz, lat, cyc});
    display_32bit_answer = 1'b1;
    wait_done(40);
    tick(3);
    check({tag, "_busy_cycles"}, 32'(busy_total - b0), 32'(exp_busy));
    check({tag, "_hold"}, display_value, val);
    display_32bit_answer = 1'b0;
    tick();
    check({tag, "_valid_drop"}, {31'h0, answer_valid}, 32'h0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    #1;
    check("reset_display", display_value, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_valid", {31'h0, answer_valid}, 32'h0);
    check("reset_div_zero", {31'h0, div_zero}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick();

    load(16'h1234, 16'h0042, 2'b00);
    run("add", 32'h0000_1276, 1'b0, 1, 0);

    load(16'd3, 16'd5, 2'b01);
    run("sub", 32'hFFFF_FFFE, 1'b0, 1, 0);

    load(16'hFFFF, 16'hFFFF, 2'b10);
    run("mul", 32'hFFFE_0001, 1'b0, 17, 16);

    load(16'd100, 16'd7, 2'b11);
    run("div", 32'h0002_000E, 1'b0, 17, 16);

    load(16'd100, 16'd0, 2'b11);
    run("div0", 32'hFFFF_FFFF, 1'b1, 1, 0);
    check("div_zero_sticky", {31'h0, div_zero}, 32'h1);

    // Abort a multiply part-way, then rerun it in full.
    load(16'h1234, 16'h5678, 2'b10);
    display_32bit_answer = 1'b1;
    tick(5);
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    check("abort_div_zero_cleared", {31'h0, div_zero}, 32'h0);
    display_32bit_answer = 1'b0;
    tick();
    check("abort_busy_after", {31'h0, busy}, 32'h0);
    check("abort_valid_after", {31'h0, answer_valid}, 32'h0);
    run("mul_rerun", 32'h0626_0060, 1'b0, 17, 16);

    // Reset in the middle of a multiply.
    load(16'hFFFF, 16'hFFFF, 2'b10);
    display_32bit_answer = 1'b1;
    tick(7);
    check("rst_mid_busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    display_32bit_answer = 1'b0;
    #1;
    check("rst_mid_display", display_value, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_valid", {31'h0, answer_valid}, 32'h0);
    check("rst_mid_div_zero", {31'h0, div_zero}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_busy", {31'h0, busy}, 32'h0);
    check("post_rst_valid", {31'h0, answer_valid}, 32'h0);
    check("post_rst_display", display_value, 32'h0);
    // Operands were cleared by reset, so a fresh launch adds 0 + 0.
    run("post_rst_add", 32'h0000_0000, 1'b0, 1, 0);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
